// File: rtl/rs_decode_scheduler.sv
// Round-robin front end sharing one RS decoder: stage a whole frame, pulse start, stream it gap-free, tag outputs.
// Optional statistics counters are built when RS_SCHED_STATS_EN is defined.
module rs_decode_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int MAX_CW  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*6-1:0]   req_len,
  output logic [NUM_REQ-1:0]     grant,
  input  logic [NUM_REQ*8-1:0]   src_data,
  input  logic [NUM_REQ-1:0]     src_valid,
  output logic [NUM_REQ-1:0]     src_ready,
  output logic                   dec_start,
  output logic [7:0]             dec_codeword,
  output logic                   dec_valid,
  input  logic [7:0]             dec_out,
  input  logic                   dec_out_valid,
  input  logic                   dec_done,
  output logic [7:0]             rsp_data,
  output logic                   rsp_valid,
  output logic [2:0]             rsp_id,
  output logic                   busy,
  output logic                   err,
  output logic [15:0]            stat_frames,
  output logic [15:0]            stat_errs
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = (MAX_CW > 1) ? $clog2(MAX_CW) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, COLLECT, START, FEED, DRAIN} state_t;
  state_t state, state_nx;

  logic [IW-1:0] ptr, sel, pick;
  logic          found;
  logic [5:0]    pick_len, len, cnt, kidx, ocnt;
  logic [6:0]    ocnt_eff;
  logic [TW-1:0] timer;
  logic [7:0]    stage_mem [MAX_CW];
  logic          len_bad, accept, last_in, last_out, to_hit;
  logic          drain_exit, drain_clean, err_set;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // First requester at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int o = 0; o < NUM_REQ; o++) begin
      if (!found && req[(int'(ptr) + o) % NUM_REQ]) begin
        found = 1'b1;
        pick  = IW'((int'(ptr) + o) % NUM_REQ);
      end
    end
  end

  assign pick_len    = req_len[6*int'(pick) +: 6];
  assign len_bad     = (pick_len == 6'd0) || (int'(pick_len) > MAX_CW);
  assign accept      = (state == COLLECT) && src_valid[sel];
  assign last_in     = accept && (cnt == len - 6'd1);
  assign last_out    = (kidx == len - 6'd1);
  // A byte arriving together with done still counts toward the length check.
  assign ocnt_eff    = {1'b0, ocnt} + {6'd0, dec_out_valid};
  assign to_hit      = (int'(timer) + 1 >= TIMEOUT);
  assign drain_exit  = dec_done || to_hit;
  assign drain_clean = dec_done && (ocnt_eff == {1'b0, len});
  assign err_set     = (state == IDLE && found && len_bad) ||
                       (state == DRAIN && drain_exit && !drain_clean);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    grant        = '0;
    src_ready    = '0;
    dec_start    = 1'b0;
    dec_valid    = 1'b0;
    dec_codeword = 8'h00;
    case (state)
      IDLE: if (found && !len_bad) state_nx = COLLECT;
      COLLECT: begin
        grant[sel]     = 1'b1;
        src_ready[sel] = 1'b1;
        if (last_in) state_nx = START;
      end
      START: begin
        grant[sel] = 1'b1;
        dec_start  = 1'b1;
        state_nx   = FEED;
      end
      FEED: begin
        grant[sel]   = 1'b1;
        dec_valid    = 1'b1;
        dec_codeword = stage_mem[kidx[AW-1:0]];
        if (last_out) state_nx = DRAIN;
      end
      DRAIN: begin
        grant[sel] = 1'b1;
        if (drain_exit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) stage_mem[cnt[AW-1:0]] <= src_data[8*int'(sel) +: 8];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      sel       <= '0;
      len       <= '0;
      cnt       <= '0;
      kidx      <= '0;
      ocnt      <= '0;
      timer     <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      err       <= err_set;
      case (state)
        IDLE: if (found) begin
          sel  <= pick;
          len  <= pick_len;
          cnt  <= '0;
          kidx <= '0;
          if (len_bad) begin
            rsp_id <= 3'(pick);
            ptr    <= wrap_inc(pick);
          end
        end
        COLLECT: if (accept && cnt != '1) cnt <= cnt + 6'd1;
        FEED: begin
          if (kidx != '1) kidx <= kidx + 6'd1;
          ocnt  <= '0;
          timer <= '0;
        end
        DRAIN: begin
          if (dec_out_valid) begin
            rsp_valid <= 1'b1;
            rsp_data  <= dec_out;
            rsp_id    <= 3'(sel);
            if (ocnt != '1) ocnt <= ocnt + 6'd1;
          end
          if (timer != '1) timer <= timer + 1'b1;
          if (drain_exit) begin
            ptr <= wrap_inc(sel);
            if (!drain_clean) rsp_id <= 3'(sel);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RS_SCHED_STATS_EN
  logic [15:0] frames_q, errs_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_q <= '0;
      errs_q   <= '0;
    end else begin
      if (state == DRAIN && drain_exit && drain_clean) frames_q <= frames_q + 16'd1;
      if (err_set) errs_q <= errs_q + 16'd1;
    end
  end
  assign stat_frames = frames_q;
  assign stat_errs   = errs_q;
`else
  assign stat_frames = 16'h0000;
  assign stat_errs   = 16'h0000;
`endif
endmodule

// File: tb/tb_rs_decode_scheduler.sv
// Randomized bench for rs_decode_scheduler: per-requester frame queues, echo decoder model, RR scoreboard.
module tb_rs_decode_scheduler;
  localparam int N     = 4;
  localparam int MAXCW = 32;
  localparam int TMO   = 255;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*6-1:0] req_len = '0;
  logic [N-1:0]   grant;
  logic [N*8-1:0] src_data = '0;
  logic [N-1:0]   src_valid = '0;
  logic [N-1:0]   src_ready;
  logic           dec_start;
  logic [7:0]     dec_codeword;
  logic           dec_valid;
  logic [7:0]     dec_out = '0;
  logic           dec_out_valid = 1'b0;
  logic           dec_done = 1'b0;
  logic [7:0]     rsp_data;
  logic           rsp_valid;
  logic [2:0]     rsp_id;
  logic           busy, err;
  logic [15:0]    stat_frames, stat_errs;

  always #5 clk = ~clk;

  rs_decode_scheduler #(.NUM_REQ(N), .MAX_CW(MAXCW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .grant(grant),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .dec_start(dec_start), .dec_codeword(dec_codeword), .dec_valid(dec_valid),
    .dec_out(dec_out), .dec_out_valid(dec_out_valid), .dec_done(dec_done),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .busy(busy), .err(err), .stat_frames(stat_frames), .stat_errs(stat_errs)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Stimulus and reference state
  int         fr_len  [N][$];
  logic [7:0] fr_byte [N][$];
  logic [7:0] act_bytes [$];
  logic [7:0] got_bytes [$];
  logic [7:0] dq [$];
  logic [7:0] emit_q [$];
  int         grant_log [$];
  int         err_log [$];
  int mptr = 0, act_id = -1, act_len = 0, si = 0;
  int starts = 0, vcycles = 0, run = 0, maxrun = 0, drain_cyc = 0;
  int mode = 0, gap_mode = 0, gcnt = 0, dlat = 0;
  int exp_frames = 0, exp_errs = 0;
  bit fed = 0, dfeed = 0, emitting = 0, hs = 0;

  function automatic bit is_bad(input int l);
    return (l == 0) || (l > MAXCW);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int o = 0; o < N; o++) if (r[(p + o) % N]) return (p + o) % N;
    return -1;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (fr_len[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_frame(input int id, input int len, input int base);
    fr_len[id].push_back(len);
    if (!is_bad(len))
      for (int k = 0; k < len; k++)
        fr_byte[id].push_back((base < 0) ? 8'($urandom) : 8'(base + k));
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req[i] = (fr_len[i].size() > 0);
      req_len[6*i +: 6] = req[i] ? 6'(fr_len[i][0]) : 6'($urandom);
    end
  endtask

  task automatic finalize();
    bit exp_err;
    int nexp;
    exp_err = (mode != 0);
    nexp    = (mode == 1) ? act_len - 1 : act_len;
    chk("dec_start_cnt", starts, 1);
    chk("feed_run", maxrun, act_len);
    chk("feed_cycles", vcycles, act_len);
    chk("frame_err", err, exp_err);
    if (exp_err) chk("frame_err_id", rsp_id, act_id);
    chk("rsp_count", got_bytes.size(), nexp);
    for (int k = 0; k < nexp && k < got_bytes.size(); k++) chk("rsp_data", got_bytes[k], act_bytes[k]);
    if (mode == 2) chk("drain_cycles", drain_cyc, TMO);
    mptr = (act_id + 1) % N;
    if (exp_err) exp_errs++; else exp_frames++;
    act_id = -1;
  endtask

  task automatic step();
    logic [N-1:0] req_prev;
    int e, id;
    bit v;
    req_prev = req;
    @(posedge clk); #1;
    if (hs) si++;
    if (act_id < 0 && !rst) begin
      if (grant != '0) begin
        e  = rr_pick(req_prev, mptr);
        id = -1;
        for (int i = 0; i < N; i++) if (grant[i]) id = i;
        chk("grant_onehot", $countones(grant), 1);
        chk("grant_id", id, e);
        if (e >= 0) begin
          chk("grant_len_ok", is_bad(fr_len[e][0]), 0);
          act_id  = e;
          act_len = fr_len[e].pop_front();
          act_bytes.delete();
          if (!is_bad(act_len)) for (int k = 0; k < act_len; k++) act_bytes.push_back(fr_byte[e].pop_front());
          got_bytes.delete();
          si = 0; starts = 0; vcycles = 0; run = 0; maxrun = 0; fed = 0; drain_cyc = 0;
          grant_log.push_back(e);
        end
      end else if (err) begin
        e = rr_pick(req_prev, mptr);
        chk("err_id", rsp_id, e);
        if (e >= 0) begin
          chk("err_badlen", is_bad(fr_len[e][0]), 1);
          if (!is_bad(fr_len[e][0])) for (int k = 0; k < fr_len[e][0]; k++) void'(fr_byte[e].pop_front());
          void'(fr_len[e].pop_front());
          mptr = (e + 1) % N;
          err_log.push_back(e);
          exp_errs++;
        end
      end
    end else if (act_id >= 0 && !rst) begin
      chk("ready_lane", src_ready & ~grant, 0);
      if (dec_start) starts++;
      if (dec_valid) begin
        vcycles++; run++;
        if (run > maxrun) maxrun = run;
      end else if (run > 0) begin
        fed = 1; run = 0;
      end
      if (fed && busy && !dec_valid) drain_cyc++;
      if (rsp_valid) begin
        got_bytes.push_back(rsp_data);
        chk("rsp_id", rsp_id, act_id);
      end
      if (!busy) finalize();
    end
    // Echo decoder: capture the fed codeword, wait a little, return it, then hold done.
    dec_out_valid = 1'b0;
    dec_out       = 8'($urandom);
    if (dec_start) begin dec_done = 1'b0; dq.delete(); end
    if (dec_valid) begin
      dq.push_back(dec_codeword);
      dfeed = 1;
    end else if (dfeed) begin
      dfeed  = 0;
      emit_q = dq;
      if (mode == 1 && emit_q.size() > 0) void'(emit_q.pop_back());
      dlat     = $urandom_range(0, 3);
      emitting = 1;
    end
    if (emitting) begin
      if (dlat > 0) dlat--;
      else if (emit_q.size() > 0) begin
        dec_out_valid = 1'b1;
        dec_out       = emit_q.pop_front();
      end else begin
        emitting = 0;
        if (mode != 2) dec_done = 1'b1;
      end
    end
    // Sources: granted lane follows the gap pattern, other lanes babble.
    src_valid = '0;
    for (int i = 0; i < N; i++) begin
      src_data[8*i +: 8] = 8'($urandom);
      if (i != act_id && $urandom_range(0, 3) == 0) src_valid[i] = 1'b1;
    end
    if (act_id >= 0 && si < act_len) begin
      gcnt++;
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = 1'($urandom_range(0, 1));
        default: v = (gcnt % 3 == 0);
      endcase
      src_valid[act_id] = v;
      src_data[8*act_id +: 8] = act_bytes[si];
    end
    hs = (act_id >= 0) && src_valid[act_id] && src_ready[act_id];
    drive_req();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    act_id = -1; mptr = 0; dq.delete(); emit_q.delete();
    emitting = 0; dfeed = 0; hs = 0; exp_frames = 0; exp_errs = 0;
    dec_done = 1'b0; dec_out_valid = 1'b0; src_valid = '0;
    step();
    chk("reset_zero", {grant, src_ready, dec_start, dec_valid, dec_codeword, rsp_valid,
                       rsp_data, rsp_id, busy, err, stat_frames, stat_errs}, 64'd0);
    rst = 1'b0;
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((pending() || act_id >= 0 || busy) && n < budget) begin
      step();
      n++;
    end
    chk("run_budget", n < budget, 1);
  endtask

  task automatic stats_check();
`ifdef RS_SCHED_STATS_EN
    chk("stat_frames", stat_frames, exp_frames);
    chk("stat_errs", stat_errs, exp_errs);
`else
    chk("stat_frames_off", stat_frames, 0);
    chk("stat_errs_off", stat_errs, 0);
`endif
  endtask

  initial begin
    int exp_b [5];
    int n;
    exp_b = '{0, 1, 2, 3, 0};
    apply_reset();

    // Single frame, bytes 11..15
    add_frame(0, 5, 11);
    run_idle(500);
    chk("a_busy", busy, 0);
    stats_check();

    // All four requesting from reset: 0,1,2,3,0
    apply_reset();
    grant_log.delete();
    for (int i = 0; i < N; i++) add_frame(i, $urandom_range(1, MAXCW), -1);
    add_frame(0, $urandom_range(1, MAXCW), -1);
    run_idle(3000);
    chk("b_count", grant_log.size(), 5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) chk("b_order", grant_log[k], exp_b[k]);

    // Only 2, then everyone: next is 3
    grant_log.delete();
    add_frame(2, 4, -1);
    n = 0;
    while (act_id != 2 && n < 100) begin step(); n++; end
    chk("b_grant2", act_id, 2);
    for (int i = 0; i < N; i++) add_frame(i, $urandom_range(1, MAXCW), -1);
    run_idle(3000);
    chk("b_next", (grant_log.size() > 1) ? grant_log[1] : -1, 3);
    stats_check();

    // Two-cycle source gaps
    gap_mode = 2;
    add_frame(1, 4, -1);
    run_idle(500);
    gap_mode = 0;

    // Bad lengths
    err_log.delete();
    add_frame(1, 0, -1);
    add_frame(3, 33, -1);
    add_frame(2, 6, -1);
    run_idle(500);
    chk("bad_err_count", err_log.size(), 2);
    stats_check();

    // Decoder that never finishes
    apply_reset();
    mode = 2;
    add_frame(2, 3, -1);
    run_idle(2000);
    mode = 0;
    chk("to_idle", busy, 0);
    stats_check();

    // Decoder returning one byte short
    mode = 1;
    add_frame(0, 7, -1);
    run_idle(500);
    mode = 0;
    stats_check();

    // Reset in FEED, then a clean frame
    add_frame(1, 10, -1);
    n = 0;
    while (!(act_id == 1 && dec_valid) && n < 200) begin step(); n++; end
    chk("rst_reach_feed", dec_valid, 1);
    apply_reset();
    add_frame(1, 8, -1);
    run_idle(500);
    stats_check();

    // Random traffic
    gap_mode = 1;
    for (int b = 0; b < 8; b++) begin
      for (int f = 0; f < 5; f++) begin
        int id, len;
        id  = $urandom_range(0, N - 1);
        len = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 63))
                                          : $urandom_range(1, MAXCW);
        add_frame(id, len, -1);
      end
      n = $urandom_range(0, 30);
      for (int s = 0; s < n; s++) step();
    end
    run_idle(30000);
    stats_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
